// File: rtl/jtag_debug_scan_master.sv
// Sysclk-domain virtual-JTAG scan initiator: runs one UIR/CDR/SDR/UDR/RTI sequence per
// accepted command against the debug module's vji_* port and returns the captured DR word.
module jtag_debug_scan_master #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int PW = (2 * TCK_DIV > 2) ? $clog2(2 * TCK_DIV) : 1;
    localparam int BW = (DR_WIDTH > 2) ? $clog2(DR_WIDTH) : 1;
    localparam logic [PW-1:0] PH_LAST   = PW'(2 * TCK_DIV - 1);
    localparam logic [PW-1:0] PH_SAMPLE = PW'(TCK_DIV - 1);
    localparam logic [PW-1:0] PH_HIGH   = PW'(TCK_DIV);
    localparam logic [PW-1:0] PH_ONE    = PW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DR_WIDTH - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UIR  = 3'd1,
        ST_CDR  = 3'd2,
        ST_SDR  = 3'd3,
        ST_UDR  = 3'd4,
        ST_RTI  = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       ph_q, ph_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [DR_WIDTH-1:0] shift_q, shift_d;
    logic                tdi_q, tdi_d;
    logic                tck_q, tck_d;
    logic                uir_q, uir_d, cdr_q, cdr_d, sdr_q, sdr_d, udr_q, udr_d, rti_q, rti_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DR_WIDTH-1:0] rsp_dr_q, rsp_dr_d;
    logic [IR_WIDTH-1:0] rsp_ir_out_q, rsp_ir_out_d;
    logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
    logic                cmd_ready_q, cmd_ready_d;

    logic accept_s, period_end_s, sample_s;

    assign accept_s     = cmd_valid && (state_q == ST_IDLE);
    assign period_end_s = (ph_q == PH_LAST);
    // tdo and ir_out are sampled in the last low-phase cycle, just before tck rises
    assign sample_s     = (ph_q == PH_SAMPLE);

    // State, phase and bit-counter register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ph_q    <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
        end
    end

    // Next-state logic: every non-idle state advances only on a tck period boundary
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        if (state_q == ST_IDLE) begin
            ph_d = '0;
        end else if (period_end_s) begin
            ph_d = '0;
        end else begin
            ph_d = ph_q + PH_ONE;
        end
        case (state_q)
            ST_IDLE: begin
                bit_d = '0;
                if (accept_s) state_d = ST_UIR;
                else          state_d = ST_IDLE;
            end
            ST_UIR: begin
                if (period_end_s) state_d = ST_CDR;
                else              state_d = ST_UIR;
            end
            ST_CDR: begin
                bit_d = '0;
                if (period_end_s) state_d = ST_SDR;
                else              state_d = ST_CDR;
            end
            ST_SDR: begin
                if (period_end_s) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_UDR;
                        bit_d   = bit_q;
                    end else begin
                        state_d = ST_SDR;
                        bit_d   = bit_q + BIT_ONE;
                    end
                end else begin
                    state_d = ST_SDR;
                end
            end
            ST_UDR: begin
                if (period_end_s) state_d = ST_RTI;
                else              state_d = ST_UDR;
            end
            ST_RTI: begin
                if (period_end_s) state_d = ST_IDLE;
                else              state_d = ST_RTI;
            end
            default: begin
                state_d = ST_IDLE;
                bit_d   = '0;
            end
        endcase
    end

    // Output logic: next values of all registered outputs, derived from the next state
    always_comb begin
        shift_d      = shift_q;
        ir_in_d      = ir_in_q;
        tdi_d        = 1'b0;
        rsp_dr_d     = rsp_dr_q;
        rsp_ir_out_d = rsp_ir_out_q;

        if (accept_s) begin
            shift_d = cmd_dr;
            ir_in_d = cmd_ir;
        end else if ((state_q == ST_SDR) && sample_s) begin
            shift_d = {vji_tdo, shift_q[DR_WIDTH-1:1]};
        end else begin
            shift_d = shift_q;
        end

        if (state_d == ST_SDR) begin
            if (ph_d == '0) tdi_d = shift_d[0];
            else            tdi_d = tdi_q;
        end else begin
            tdi_d = 1'b0;
        end

        if ((state_q == ST_SDR) && (state_d == ST_UDR)) rsp_dr_d = shift_q;
        else                                            rsp_dr_d = rsp_dr_q;

        if ((state_q == ST_CDR) && sample_s) rsp_ir_out_d = vji_ir_out;
        else                                 rsp_ir_out_d = rsp_ir_out_q;

        tck_d       = (state_d != ST_IDLE) && (ph_d >= PH_HIGH);
        uir_d       = (state_d == ST_UIR);
        cdr_d       = (state_d == ST_CDR);
        sdr_d       = (state_d == ST_SDR);
        udr_d       = (state_d == ST_UDR);
        rti_d       = (state_d == ST_RTI);
        cmd_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_q == ST_RTI) && period_end_s;
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shift_q      <= '0;
            tdi_q        <= 1'b0;
            tck_q        <= 1'b0;
            uir_q        <= 1'b0;
            cdr_q        <= 1'b0;
            sdr_q        <= 1'b0;
            udr_q        <= 1'b0;
            rti_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_dr_q     <= '0;
            rsp_ir_out_q <= '0;
            ir_in_q      <= '0;
            cmd_ready_q  <= 1'b1;
        end else begin
            shift_q      <= shift_d;
            tdi_q        <= tdi_d;
            tck_q        <= tck_d;
            uir_q        <= uir_d;
            cdr_q        <= cdr_d;
            sdr_q        <= sdr_d;
            udr_q        <= udr_d;
            rti_q        <= rti_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_dr_q     <= rsp_dr_d;
            rsp_ir_out_q <= rsp_ir_out_d;
            ir_in_q      <= ir_in_d;
            cmd_ready_q  <= cmd_ready_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_dr     = rsp_dr_q;
    assign rsp_ir_out = rsp_ir_out_q;
    assign vji_tck    = tck_q;
    assign vji_tdi    = tdi_q;
    assign vji_ir_in  = ir_in_q;
    assign vji_uir    = uir_q;
    assign vji_cdr    = cdr_q;
    assign vji_sdr    = sdr_q;
    assign vji_udr    = udr_q;
    assign vji_rti    = rti_q;

endmodule

// File: tb/tb_jtag_debug_scan_master.sv
// Self-checking bench for jtag_debug_scan_master: scoreboard of expected responses,
// loopback and shift-register target models, plus a TCK_DIV=1 instance.
module tb_jtag_debug_scan_master;

    localparam int W = 38;

    typedef struct {
        logic [W-1:0] dr;
        int           due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic         cmd_valid, cmd_ready;
    logic [1:0]   cmd_ir;
    logic [W-1:0] cmd_dr;
    logic         rsp_valid;
    logic [W-1:0] rsp_dr;
    logic [1:0]   rsp_ir_out;
    logic         vji_tck, vji_tdi, vji_tdo;
    logic [1:0]   vji_ir_in, vji_ir_out;
    logic         vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    logic         c1_valid, c1_ready;
    logic [1:0]   c1_ir;
    logic [W-1:0] c1_dr;
    logic         c1_rsp_valid;
    logic [W-1:0] c1_rsp_dr;
    logic [1:0]   c1_rsp_ir_out;
    logic         c1_tck, c1_tdi;
    logic [1:0]   c1_ir_in;
    logic         c1_uir, c1_cdr, c1_sdr, c1_udr, c1_rti;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sb_q[$];
    exp_t sb1_q[$];
    int   n_uir, n_cdr, n_sdr, n_udr, n_rti, n_over, n_rise;

    bit           use_model = 1'b0;
    logic [W-1:0] tgt_q      = '0;
    logic [W-1:0] tgt_at_udr = '0;
    logic [W-1:0] tgt_load   = 38'h12_3456_789A;
    logic         tgt_ptck   = 1'b0;
    logic         tgt_pudr   = 1'b0;

    assign vji_tdo = use_model ? tgt_q[0] : vji_tdi;

    always @(posedge clk) cyc <= cyc + 1;

    // Target DR model: capture on tck rise in CDR, shift on tck rise in SDR
    always @(negedge clk) begin
        if (vji_tck && !tgt_ptck) begin
            if (vji_cdr)      tgt_q <= tgt_load;
            else if (vji_sdr) tgt_q <= {vji_tdi, tgt_q[W-1:1]};
        end
        if (vji_udr && !tgt_pudr) tgt_at_udr <= tgt_q;
        tgt_ptck <= vji_tck;
        tgt_pudr <= vji_udr;
    end

    jtag_debug_scan_master #(.DR_WIDTH(W), .IR_WIDTH(2), .TCK_DIV(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
        .rsp_valid(rsp_valid), .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out),
        .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
        .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
        .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
    );

    jtag_debug_scan_master #(.DR_WIDTH(W), .IR_WIDTH(2), .TCK_DIV(1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(c1_valid), .cmd_ready(c1_ready), .cmd_ir(c1_ir), .cmd_dr(c1_dr),
        .rsp_valid(c1_rsp_valid), .rsp_dr(c1_rsp_dr), .rsp_ir_out(c1_rsp_ir_out),
        .vji_tck(c1_tck), .vji_tdi(c1_tdi), .vji_tdo(c1_tdi),
        .vji_ir_in(c1_ir_in), .vji_ir_out(2'b00),
        .vji_uir(c1_uir), .vji_cdr(c1_cdr), .vji_sdr(c1_sdr), .vji_udr(c1_udr), .vji_rti(c1_rti)
    );

    task automatic issue(input logic [1:0] ir, input logic [W-1:0] dr,
                         input logic [W-1:0] exp_dr, input int lat);
        exp_t e;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL issue_ready: cmd_ready=%b want 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_ir    = ir;
        cmd_dr    = dr;
        e.dr  = exp_dr;
        e.due = cyc + lat;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name, input logic [1:0] exp_ir, input int budget);
        exp_t e;
        int   irmis = 0;
        logic ptck  = 1'b0;
        bit   got   = 1'b0;
        n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rti = 0; n_over = 0; n_rise = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (vji_ir_in !== exp_ir) irmis++;
            n_uir += int'(vji_uir);
            n_cdr += int'(vji_cdr);
            n_sdr += int'(vji_sdr);
            n_udr += int'(vji_udr);
            n_rti += int'(vji_rti);
            if ($countones({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}) > 1) n_over++;
            if (vji_tck && !ptck) n_rise++;
            ptck = vji_tck;
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL %s_unexpected: rsp_valid with empty scoreboard", name);
                end else begin
                    e = sb_q.pop_front();
                    if (rsp_dr !== e.dr) begin
                        bad++;
                        $display("FAIL %s_data: rsp_dr=%h want %h", name, rsp_dr, e.dr);
                    end
                    total++;
                    if (cyc !== e.due) begin
                        bad++;
                        $display("FAIL %s_latency: rsp at cycle %0d want %0d", name, cyc, e.due);
                    end
                end
                total++;
                if (cmd_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL %s_ready_at_rsp: cmd_ready=%b want 1", name, cmd_ready);
                end
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: no rsp_valid within %0d cycles", name, budget);
        end
        total++;
        if (irmis != 0) begin
            bad++;
            $display("FAIL %s_ir_in: %0d cycles with vji_ir_in != %0d", name, irmis, exp_ir);
        end
    endtask

    task automatic check_reset_values(input string name);
        logic [12:0] obs;
        obs = {cmd_ready, rsp_valid, rsp_ir_out, vji_ir_in, vji_tck, vji_tdi,
               vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti};
        total++;
        if (obs !== {1'b1, 12'b0}) begin
            bad++;
            $display("FAIL %s_outputs: got %b want %b", name, obs, {1'b1, 12'b0});
        end
        total++;
        if (rsp_dr !== '0) begin
            bad++;
            $display("FAIL %s_rsp_dr: got %h want 0", name, rsp_dr);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset_init");
        reset_n = 1'b1;
    endtask

    task automatic test_loopback();
        use_model  = 1'b0;
        vji_ir_out = 2'b01;
        issue(2'd2, 38'h2A_AAAA_AAAA, 38'h2A_AAAA_AAAA, 169);
        wait_rsp("loopback", 2'd2, 250);
        total++;
        if (rsp_ir_out !== 2'b01) begin
            bad++;
            $display("FAIL loopback_ir_out: rsp_ir_out=%b want 01", rsp_ir_out);
        end
    endtask

    task automatic test_target_model();
        use_model = 1'b1;
        issue(2'd1, 38'h3F_FFFF_FFFF, 38'h12_3456_789A, 169);
        wait_rsp("model", 2'd1, 250);
        total++;
        if (tgt_at_udr !== 38'h3F_FFFF_FFFF) begin
            bad++;
            $display("FAIL model_target_at_udr: target=%h want 3fffffffff", tgt_at_udr);
        end
        use_model = 1'b0;
    endtask

    task automatic test_strobes();
        int obs[7];
        int want[7];
        issue(2'd0, 38'h01_2345_6789, 38'h01_2345_6789, 169);
        wait_rsp("strobes", 2'd0, 250);
        obs  = '{n_uir, n_cdr, n_sdr, n_udr, n_rti, n_over, n_rise};
        want = '{4, 4, 152, 4, 4, 0, 42};
        for (int i = 0; i < 7; i++) begin
            total++;
            if (obs[i] !== want[i]) begin
                bad++;
                $display("FAIL strobes_count%0d: got %0d want %0d", i, obs[i], want[i]);
            end
        end
    endtask

    task automatic test_busy();
        exp_t         e;
        int           rdy_bad = 0;
        int           ir_bad  = 0;
        bit           got     = 1'b0;
        logic [W-1:0] first_dr  = 38'h0F_0F0F_0F0F;
        logic [W-1:0] second_dr = 38'h30_C30C_30C3;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_ir    = 2'd1;
        cmd_dr    = first_dr;
        e.dr  = first_dr;
        e.due = cyc + 169;
        sb_q.push_back(e);
        for (int i = 0; i < 250 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                e = sb_q.pop_front();
                total++;
                if (rsp_dr !== e.dr) begin
                    bad++;
                    $display("FAIL busy_first_data: rsp_dr=%h want %h", rsp_dr, e.dr);
                end
                total++;
                if (cyc !== e.due) begin
                    bad++;
                    $display("FAIL busy_first_latency: cycle %0d want %0d", cyc, e.due);
                end
                cmd_ir = 2'd3;
                cmd_dr = second_dr;
                e.dr  = second_dr;
                e.due = cyc + 169;
                sb_q.push_back(e);
            end else begin
                if (cmd_ready !== 1'b0) rdy_bad++;
                if (vji_ir_in !== 2'd1) ir_bad++;
                cmd_dr = W'({$urandom(), $urandom()});
                cmd_ir = 2'($urandom_range(0, 3));
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL busy_timeout: first rsp_valid missing");
        end
        total++;
        if (rdy_bad != 0 || ir_bad != 0) begin
            bad++;
            $display("FAIL busy_ignored: ready_high=%0d ir_changed=%0d want 0 0", rdy_bad, ir_bad);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_rsp("busy_second", 2'd3, 250);
    endtask

    task automatic test_tckdiv1();
        exp_t e;
        bit   got = 1'b0;
        @(negedge clk);
        c1_valid = 1'b1;
        c1_ir    = 2'd1;
        c1_dr    = 38'h00_0000_0001;
        e.dr  = 38'h00_0000_0001;
        e.due = cyc + 85;
        sb1_q.push_back(e);
        @(posedge clk);
        #1;
        c1_valid = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (c1_rsp_valid === 1'b1) begin
                got = 1'b1;
                e = sb1_q.pop_front();
                total++;
                if (c1_rsp_dr !== e.dr) begin
                    bad++;
                    $display("FAIL div1_data: rsp_dr=%h want %h", c1_rsp_dr, e.dr);
                end
                total++;
                if (cyc !== e.due) begin
                    bad++;
                    $display("FAIL div1_latency: cycle %0d want %0d", cyc, e.due);
                end
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL div1_timeout: no rsp_valid within 200 cycles");
        end
    endtask

    task automatic test_reset_mid_scan();
        int udr_seen = 0;
        int rsp_seen = 0;
        use_model  = 1'b0;
        vji_ir_out = 2'b10;
        issue(2'd3, 38'h15_5555_5555, 38'h15_5555_5555, 169);
        repeat (60) @(negedge clk);
        total++;
        if (vji_sdr !== 1'b1) begin
            bad++;
            $display("FAIL midreset_in_sdr: vji_sdr=%b want 1", vji_sdr);
        end
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_values("midreset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        sb_q.delete();
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            udr_seen += int'(vji_udr);
            rsp_seen += int'(rsp_valid);
        end
        total++;
        if (udr_seen != 0 || rsp_seen != 0) begin
            bad++;
            $display("FAIL midreset_no_update: udr_cycles=%0d rsp_pulses=%0d want 0 0", udr_seen, rsp_seen);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        cmd_valid  = 1'b0;
        cmd_ir     = 2'd0;
        cmd_dr     = '0;
        c1_valid   = 1'b0;
        c1_ir      = 2'd0;
        c1_dr      = '0;
        vji_ir_out = 2'b00;
        test_reset();
        test_loopback();
        test_target_model();
        test_strobes();
        test_busy();
        test_tckdiv1();
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/jtag_debug_scan_master.md
# jtag_debug_scan_master

Sysclk-domain scan initiator that drives the Nios II debug module's virtual-JTAG port (ir_in, tck, tdi, uir/cdr/sdr/udr/rti strobes) and collects its tdo. Each command runs one complete IR-select / capture / shift / update sequence. This lets on-chip logic, or a simulation bench, exercise the debug module's TCK-side shift register and sysclk take_action decode without a physical JTAG cable. Sits between an Avalon-side command source and the debug module wrapper's vji_* nets.

## Interface
- DR_WIDTH, 38: data-register length in bits.
- IR_WIDTH, 2: virtual IR width.
- TCK_DIV, 2: clk cycles per tck half-period; legal range ≥1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted on the cycle where cmd_valid & cmd_ready.
- cmd_ir  in  IR_WIDTH  virtual IR value for the scan.
- cmd_dr  in  DR_WIDTH  data shifted in, LSB first.
- rsp_valid  out  1  one-cycle pulse at scan completion.
- rsp_dr  out  DR_WIDTH  data captured from tdo; held until the next rsp_valid.
- rsp_ir_out  out  IR_WIDTH  vji_ir_out, sampled during the CDR period.
- vji_tck  out  1  generated test clock.
- vji_tdi  out  1  serial data to target.
- vji_tdo  in  1  serial data from target.
- vji_ir_in  out  IR_WIDTH  IR to target.
- vji_ir_out  in  IR_WIDTH  IR status from target.
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual state strobes.

## Operation
- States: IDLE → UIR → CDR → SDR → UDR → RTI → IDLE.
- Each non-IDLE state occupies whole tck periods:
  - period = 2·TCK_DIV clk cycles;
  - tck is low for the first TCK_DIV cycles and high for the last TCK_DIV cycles.
- Period counts per state: UIR 1, CDR 1, SDR DR_WIDTH, UDR 1, RTI 1. Total DR_WIDTH+4 periods.
- On accept:
  - cmd_dr is loaded into the shift register;
  - vji_ir_in is loaded from cmd_ir.
- vji_ir_in holds its value until the next accept. It stays stable through UDR and beyond, so the target's sysclk-side decode sees it.
- Strobes:
  - exactly one of uir/cdr/sdr/udr/rti is high in the matching state, for the full period;
  - all strobes are low in IDLE.
- SDR shifting:
  - vji_tdi = shift[0], updated at each period start;
  - tdo is sampled in the last low-phase cycle of each SDR period, i.e. the cycle before tck rises;
  - the sample is shifted in at the MSB: shift <= {tdo, shift[DR_WIDTH-1:1]}.
- After DR_WIDTH shifts, shift holds the captured word in bit order (target bit 0 at LSB). It is copied to rsp_dr at UDR entry.
- vji_tdi = 0 outside SDR.
- rsp_ir_out is sampled at the same low-phase sample point, during the CDR period.
- cmd_valid in any state other than IDLE is ignored; there is no queueing.

## Timing
- Reset values (reset_n low at a clk edge; effective next cycle, from any state including mid-SDR):
  - state IDLE, cmd_ready 1, rsp_valid 0;
  - rsp_dr 0, rsp_ir_out 0, vji_ir_in 0;
  - vji_tck 0, vji_tdi 0, all strobes 0.
- No partial update pulse (udr) is ever emitted for an aborted scan.
- Accept at cycle 0. Period p (p = 0 … DR_WIDTH+3) spans cycles 1+2·TCK_DIV·p through 2·TCK_DIV·(p+1).
- tck rises at cycle 1+2·TCK_DIV·p+TCK_DIV.
- rsp_valid pulses at cycle 1+2·TCK_DIV·(DR_WIDTH+4). In that same cycle the state is IDLE and cmd_ready = 1.
- Defaults (DR_WIDTH 38, TCK_DIV 2): rsp_valid at cycle 169; back-to-back throughput is one command per 169 cycles.
- A command accepted in the rsp_valid cycle starts UIR on the next cycle; rsp_dr is unchanged until that scan's UDR.
- tck is a divided, registered output. It never glitches, and it stays low in IDLE.

## Test plan
- Reset: hold reset_n low 3 cycles, asserting it mid-SDR of a running scan → all outputs at their reset values on the next cycle, cmd_ready = 1, no udr pulse.
- Loopback (vji_tdo tied to vji_tdi), cmd_dr = 0x2A_AAAA_AAAA, cmd_ir = 2 → rsp_valid at cycle 169, rsp_dr = 0x2A_AAAA_AAAA, vji_ir_in = 2 throughout.
- 38-bit target shift-register model (loads 0x12_3456_789A on cdr, shifts on tck rise while sdr), cmd_dr = 0x3F_FFFF_FFFF → rsp_dr = 0x12_3456_789A, model holds 0x3F_FFFF_FFFF at udr.
- Strobe order/widths: check one each of uir, cdr, udr, rti of 4 cycles and sdr of 152 cycles, no overlap, exactly 42 tck rising edges.
- Busy: cmd_valid held high with changing data during a scan → cmd_ready = 0 and only the first command runs; a second accept occurs in cycle 169, and the next rsp_valid pulses at cycle 338.
- TCK_DIV = 1 build, loopback 0x00_0000_0001 → rsp_valid at cycle 85, rsp_dr = 0x00_0000_0001.
